// File: rtl/matrix_element_serializer.sv
// Snapshots a MAX_DIM x MAX_DIM element bank on start and streams the active row x col
// window over valid/ready. Optional trailing checksum beat: MATRIX_SERIALIZER_CHECKSUM_EN.
module matrix_element_serializer #(
    parameter int WIDTH   = 8,
    parameter int MAX_DIM = 5
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [MAX_DIM*MAX_DIM-1:0][WIDTH-1:0] matrix_in,
    input  logic [2:0]                            row,
    input  logic [2:0]                            col,
    input  logic                                  start,
    output logic [WIDTH-1:0]                      elem_data,
    output logic [2:0]                            elem_row,
    output logic [2:0]                            elem_col,
    output logic                                  elem_valid,
    input  logic                                  elem_ready,
    output logic                                  elem_eol,
    output logic                                  elem_eof,
    output logic                                  busy,
    output logic                                  done
);
    localparam int          NELEM = MAX_DIM * MAX_DIM;
    localparam int          IW    = $clog2(NELEM);
    localparam logic [2:0]  MAXD  = 3'(MAX_DIM);

    typedef enum logic [1:0] {IDLE, SEND, DONE, SUM} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] snap_q [NELEM];
    logic [2:0]       row_l_q, row_l_d, col_l_q, col_l_d;
    logic [2:0]       r_q, r_d, c_q, c_d;
    logic             cap;
    logic             eol, last;
    logic [IW-1:0]    idx;
`ifdef MATRIX_SERIALIZER_CHECKSUM_EN
    logic [WIDTH-1:0] sum_q, sum_d;
`endif

    function automatic logic [2:0] clamp_dim(input logic [2:0] d);
        if (d == 3'd0) return 3'd1;
        if (d > MAXD)  return MAXD;
        return d;
    endfunction

    assign idx  = IW'(r_q) * IW'(MAX_DIM) + IW'(c_q);
    assign eol  = (c_q == col_l_q - 3'd1);
    assign last = eol && (r_q == row_l_q - 3'd1);
    assign cap  = (state_q == IDLE) && start;

    always_comb begin
        state_d    = state_q;
        row_l_d    = row_l_q;
        col_l_d    = col_l_q;
        r_d        = r_q;
        c_d        = c_q;
        elem_data  = '0;
        elem_row   = '0;
        elem_col   = '0;
        elem_valid = 1'b0;
        elem_eol   = 1'b0;
        elem_eof   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
`ifdef MATRIX_SERIALIZER_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SEND;
                    row_l_d = clamp_dim(row);
                    col_l_d = clamp_dim(col);
                    r_d     = '0;
                    c_d     = '0;
`ifdef MATRIX_SERIALIZER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            SEND: begin
                busy       = 1'b1;
                elem_valid = 1'b1;
                elem_data  = snap_q[idx];
                elem_row   = r_q;
                elem_col   = c_q;
                elem_eol   = eol;
`ifdef MATRIX_SERIALIZER_CHECKSUM_EN
                elem_eof   = 1'b0;
`else
                elem_eof   = last;
`endif
                if (elem_ready) begin
`ifdef MATRIX_SERIALIZER_CHECKSUM_EN
                    sum_d = sum_q + snap_q[idx];
`endif
                    if (last) begin
`ifdef MATRIX_SERIALIZER_CHECKSUM_EN
                        state_d = SUM;
`else
                        state_d = DONE;
`endif
                    end else if (eol) begin
                        c_d = '0;
                        r_d = r_q + 3'd1;
                    end else begin
                        c_d = c_q + 3'd1;
                    end
                end
            end
            SUM: begin
                // Checksum trailer; unreachable in the default build
                busy       = 1'b1;
                elem_valid = 1'b1;
                elem_row   = 3'd7;
                elem_col   = 3'd7;
                elem_eol   = 1'b1;
                elem_eof   = 1'b1;
`ifdef MATRIX_SERIALIZER_CHECKSUM_EN
                elem_data  = sum_q;
`endif
                if (elem_ready) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            row_l_q <= 3'd1;
            col_l_q <= 3'd1;
            r_q     <= '0;
            c_q     <= '0;
`ifdef MATRIX_SERIALIZER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            row_l_q <= row_l_d;
            col_l_q <= col_l_d;
            r_q     <= r_d;
            c_q     <= c_d;
`ifdef MATRIX_SERIALIZER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    // Snapshot only loads on an accepted start, so matrix_in may change freely mid-frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NELEM; k++) snap_q[k] <= '0;
        end else if (cap) begin
            for (int k = 0; k < NELEM; k++) snap_q[k] <= matrix_in[k];
        end
    end

endmodule

// File: doc/matrix_element_serializer.md
# matrix_element_serializer

Downstream consumer of the random matrix generator. Snapshots the 5×5 element bank (25 × WIDTH, row-major, index = r*MAX_DIM + c) on a start pulse and streams only the active row×col elements, one per beat, over a valid/ready handshake. Each beat carries row/column tags and end-of-row/end-of-frame markers for the UART/display formatter.

## Interface
- WIDTH, 8, element width in bits
- MAX_DIM, 5, maximum matrix dimension; bank holds MAX_DIM*MAX_DIM elements
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- matrix_in  in  25*WIDTH  element k at bits [k*WIDTH +: WIDTH]
- row  in  3  active rows, 1..5
- col  in  3  active columns, 1..5
- start  in  1  single-cycle request; driven from the generator's update_done rising edge
- elem_data  out  WIDTH  current element value
- elem_row  out  3  0-based row of current element
- elem_col  out  3  0-based column of current element
- elem_valid  out  1  beat presented
- elem_ready  in  1  consumer accepts beat when high with elem_valid
- elem_eol  out  1  current beat is last column of its row
- elem_eof  out  1  current beat is last element of frame
- busy  out  1  high from capture until frame complete
- done  out  1  one-cycle pulse after final beat accepted

## Operation
- States: IDLE, SEND, DONE (SUM when checksum compiled in).
- IDLE: start=1 captures matrix_in into internal 25-entry snapshot, latches clamped row/col (0→1, >MAX_DIM→MAX_DIM), sets r=c=0, goes to SEND. Snapshot is immune to later matrix_in changes.
- SEND: elem_valid=1; elem_data=snap[r*MAX_DIM+c]; elem_row=r, elem_col=c; elem_eol=(c==col_l-1); elem_eof=eol&&(r==row_l-1).
- Beat accepted on elem_valid&&elem_ready: if not eof, advance c; on eol wrap c→0, r→r+1. If eof, go DONE (or SUM).
- Outputs stable while elem_valid&&!elem_ready (no data/tag change).
- DONE: done=1 for exactly one cycle, busy=0, return to IDLE.
- start while busy (SEND/SUM/DONE) ignored; no queuing.
- Elements outside active row×col never emitted; frame length = row_l*col_l (1..25).

## Timing
- Reset values: elem_data=0, elem_row=0, elem_col=0, elem_valid=0, elem_eol=0, elem_eof=0, busy=0, done=0; state IDLE, snapshot cleared.
- start sampled at edge N → elem_valid and busy high from cycle N+1.
- With elem_ready held high: one beat per cycle; frame of K beats accepted in cycles N+1..N+K; done high in cycle N+K+1.
- done and start in same cycle: start ignored (block still busy that cycle is not true—DONE counts as busy for start purposes).
- rst asserted mid-frame: immediate return to reset values; partial frame discarded, no done pulse.
- 1×1 frame: single beat with eol=eof=1.

## Configuration
- MATRIX_SERIALIZER_CHECKSUM_EN defined: after eof beat accepted, state SUM presents one extra beat: elem_data = sum of all emitted elements mod 2^WIDTH, elem_row=7, elem_col=7, elem_eol=1, elem_eof=1; eof on the last data beat becomes 0 (eol unchanged). done follows acceptance of the SUM beat.
- Not defined: no SUM state; frame ends on last data beat with eof=1.

## Test plan
- Reset then idle, start never asserted → all outputs 0, elem_valid stays 0 for 100 cycles.
- row=2, col=3, matrix_in[k]=k+1, ready=1, start pulse → 6 beats data 1,2,3,6,7,8; tags (0,0)…(1,2); eol on beats 3 and 6; eof on beat 6; done one cycle after beat 6.
- Same frame, ready toggled 1/0 each cycle → identical 6-beat sequence, outputs stable during stalls, done after 12th cycle of SEND.
- row=0, col=7 → clamped 1×5: 5 beats, data snap[0..4], eof on beat 5; matrix_in changed after start does not alter data.
- start pulsed again at beat 3 of 25-beat frame, then rst mid-frame at beat 10 → second start ignored; after rst elem_valid=0, no done.
- Checksum build, row=col=2, elements 200,100,50,10 → 4 data beats then SUM beat data=104 (360 mod 256), tags (7,7), eof only on SUM beat.
